spi_frame_tx: RTL and testbench
===============================

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

Interface
REQ-001 Parameters: DATA_W, default 8, payload width; FIFO_DEPTH, default 4, input buffer entries (power of two).
REQ-002 Ports are listed as name, direction, width, meaning.
REQ-003 clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 tx_data  input  DATA_W  payload byte to send.
REQ-006 tx_valid  input  1  tx_data is offered this cycle.
REQ-007 tx_ready  output  1  the block accepts tx_data this cycle.
REQ-008 tx  output  1  serial frame stream, registered, to the downstream frame receiver sampling on falling clk.
REQ-009 fifo_count  output  3  number of buffered bytes, 0..FIFO_DEPTH.
REQ-010 frames_sent  output  6  count of data frames (not idle frames) fully transmitted, modulo 64.

Function
REQ-011 Frame is 11 bits, sent bit 0 first, one bit per clk:
- bit0: start bit, 0 for a data frame
- bits8:1: payload, LSB first
- bit9: even parity over the payload
- bit10: stop bit, 1
REQ-012 The idle frame is 11'h7FF (all ones); its bit0 = 1 marks it as idle.
REQ-013 Frames are sent back-to-back with no gap, because the receiver frames on a free-running 0..10 bit count.
REQ-014 State: bit_idx (0..10) and frame_reg (11 bits); tx = frame_reg[bit_idx], registered.
REQ-015 On the rising edge where bit_idx==10:
- bit_idx wraps to 0.
- If the FIFO is non-empty, frame_reg loads the frame built from the FIFO head and the head is popped.
- Otherwise frame_reg loads the idle frame.
REQ-016 On all other edges, bit_idx increments and frame_reg holds.
REQ-017 A push happens when tx_valid && tx_ready; tx_ready = (fifo_count < FIFO_DEPTH).
- tx_ready is not pop-aware: it is 0 when full, even on a pop cycle.
REQ-018 A simultaneous push and pop leaves fifo_count unchanged; FIFO order is strict first-in, first-out.
REQ-019 Latency: a byte pushed into an empty FIFO at cycle t appears as bit0 at the first frame boundary after t.
- Minimum: 1 cycle, when pushed while bit_idx==9.
- Maximum: 11 cycles.
REQ-020 A byte pushed on the same edge as a boundary pop of an empty FIFO is not sent in that frame; the idle frame is sent.
REQ-021 frames_sent increments on the edge where bit_idx==10 and frame_reg bit0==0; it wraps 63 -> 0.
REQ-022 tx_data is ignored when tx_ready==0; the offered word is neither stored nor dropped silently, and the source must hold it.

Reset
REQ-023 When rst_n is low, immediately:
- bit_idx = 0
- frame_reg = idle frame
- tx = 1
- FIFO emptied, fifo_count = 0
- frames_sent = 0
- tx_ready = 1
REQ-024 Reset mid-frame abandons the frame in flight, and buffered bytes are lost.
REQ-025 The first rising edge after rst_n deasserts advances bit_idx to 1.
- Frame alignment is defined relative to reset release.
- The downstream receiver shares clk and is released from reset in the same cycle.

Structure
REQ-026 Shared package spi_frame_pkg holds:
- FRAME_W=11
- DATA_W=8
- FIFO_DEPTH=4
- IDLE_FRAME=11'h7FF
- bit-position constants START_BIT=0, PAR_BIT=9, STOP_BIT=10
- a frame-build function: data -> 11-bit frame
REQ-027 The buffer is the single sub-module frame_fifo: synchronous, DATA_W x FIFO_DEPTH, with push/pop/count/full/empty.
REQ-028 The serializer (bit_idx, frame_reg, frames_sent) stays in spi_frame_tx.

Verification
REQ-029 Reset release with tx_valid=0 for 33 cycles:
- tx stays 1 on every cycle.
- frames_sent stays 0.
REQ-030 Push 0xA5 while bit_idx==3:
- The next frame is 11'h54A, seen on tx as bits 0,1,0,1,0,0,1,0,1,0,1.
- frames_sent goes 0 -> 1 on that frame's final edge.
REQ-031 Push 0x01 then 0x80 back-to-back:
- The frames sent in order are 11'h602 then 11'h700, with no idle frame between them.
REQ-032 Push 5 bytes 0x10..0x14 on consecutive cycles starting at bit_idx==0:
- tx_ready drops after the 4th push, with fifo_count==4.
- The 5th byte is accepted at the next boundary pop.
- All 5 bytes are sent in order.
REQ-033 Assert rst_n=0 at bit_idx==5 of a data frame with fifo_count==2:
- tx goes to 1 at once.
- After release, only idle frames are sent.
REQ-034 Send 65 data frames:
- frames_sent reads 63 after the 63rd frame, 0 after the 64th and 1 after the 65th.
- Every received frame has even parity over bits 9:1.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared constants and frame construction for the SPI frame transmitter.
//   FRAME_W     : bits per serial frame
//   DATA_W      : payload width
//   FIFO_DEPTH  : input buffer entries
//   IDLE_FRAME  : all-ones frame sent when nothing is buffered
//   START_BIT / PAR_BIT / STOP_BIT : bit positions inside a frame
//   build_frame : payload byte -> 11-bit data frame
package spi_frame_pkg;

    localparam int unsigned FRAME_W    = 11;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

    localparam int unsigned START_BIT = 0;
    localparam int unsigned PAR_BIT   = 9;
    localparam int unsigned STOP_BIT  = 10;

    // Start 0, payload LSB first in bits 8:1, even parity, stop 1.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data);
        logic [FRAME_W-1:0] f;
        f                          = '0;
        f[START_BIT]               = 1'b0;
        f[PAR_BIT-1:START_BIT+1]   = data;
        f[PAR_BIT]                 = ^data;
        f[STOP_BIT]                = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous first-in first-out byte buffer feeding the frame serializer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_push_data (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_pop_data   : current head entry
//   o_count      : number of stored entries, 0..DEPTH
//   o_full       : o_count == DEPTH
//   o_empty      : o_count == 0
module frame_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_tx.sv
// Serial frame transmitter: buffers payload bytes and streams 11-bit frames
// back-to-back, one bit per clock, inserting idle frames when empty.
//   clk, rst_n  : clock, asynchronous active-low reset
//   tx_data     : payload byte offered
//   tx_valid    : tx_data offered this cycle
//   tx_ready    : byte accepted this cycle (buffer not full)
//   tx          : registered serial output, frame bit 0 first
//   fifo_count  : buffered bytes
//   frames_sent : data frames completed, modulo 64
module spi_frame_tx #(
    parameter int unsigned DATA_W     = spi_frame_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = spi_frame_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic [2:0]        fifo_count,
    output logic [5:0]        frames_sent
);

    import spi_frame_pkg::*;

    logic [3:0]         r_bit_idx;
    logic [FRAME_W-1:0] r_frame;
    logic               r_tx;
    logic [5:0]         r_frames_sent;

    logic [3:0]         w_bit_idx_d;
    logic [FRAME_W-1:0] w_frame_d;
    logic [FRAME_W-1:0] w_shifted;
    logic               w_tx_d;
    logic               w_boundary;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_head;

    // Readiness ignores a same-cycle pop so a full buffer never takes a byte.
    assign tx_ready = !w_full;

    assign w_boundary = (r_bit_idx == 4'(STOP_BIT));
    assign w_pop      = w_boundary && !w_empty;

    frame_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (3)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (tx_valid),
        .i_push_data (tx_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_bit_idx_d = r_bit_idx + 4'd1;
        w_frame_d   = r_frame;
        if (w_boundary) begin
            w_bit_idx_d = 4'd0;
            w_frame_d   = w_empty ? IDLE_FRAME : build_frame(w_head);
        end
        // tx always shows frame_reg[bit_idx]; precompute it for the next state.
        w_shifted = w_frame_d >> w_bit_idx_d;
        w_tx_d    = w_shifted[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx     <= 4'd0;
            r_frame       <= IDLE_FRAME;
            r_tx          <= 1'b1;
            r_frames_sent <= 6'd0;
        end else begin
            r_bit_idx <= w_bit_idx_d;
            r_frame   <= w_frame_d;
            r_tx      <= w_tx_d;
            if (w_boundary && !r_frame[START_BIT]) begin
                r_frames_sent <= r_frames_sent + 6'd1;
            end
        end
    end

    assign tx          = r_tx;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_spi_frame_tx.sv
module tb_spi_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic [2:0] fifo_count;
    logic [5:0] frames_sent;

    spi_frame_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .fifo_count  (fifo_count),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bit position since reset, current frame, byte queue.
    int          m_pos;
    logic [10:0] m_frame;
    logic [7:0]  q[$];
    int          m_total;

    // Receiver side: frames rebuilt from tx, bytes still expected on the line.
    logic [10:0] rx_shift;
    logic [10:0] rx_log[$];
    logic [7:0]  exp_bytes[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        int v;
        v = 1024 + ($countones(d) % 2) * 512 + int'(d) * 2;
        return v[10:0];
    endfunction

    task automatic rx_done(input logic [10:0] f);
        logic [7:0] e;
        rx_log.push_back(f);
        if (f[0] == 1'b0) begin
            chk("rx_parity", ^f[9:1], 1'b0);
            chk("rx_stop", f[10], 1'b1);
            if (exp_bytes.size() == 0) begin
                chk("rx_unexpected_frame", f, 11'h7FF);
            end else begin
                e = exp_bytes.pop_front();
                chk("rx_payload", f[8:1], e);
            end
        end
    endtask

    // One clock: check outputs, drive inputs, advance the model. Called at negedge.
    task automatic tick(input logic v, input logic [7:0] d, output bit acc);
        chk("tx", tx, m_frame[m_pos]);
        chk("tx_ready", tx_ready, q.size() < 4);
        chk("fifo_count", fifo_count, q.size());
        chk("frames_sent", frames_sent, m_total % 64);
        rx_shift[m_pos] = tx;
        if (m_pos == 10) rx_done(rx_shift);
        acc      = v && (q.size() < 4);
        tx_valid = v;
        tx_data  = d;
        @(posedge clk);
        if (m_pos == 10) begin
            if (m_frame[0] == 1'b0) m_total++;
            m_frame = (q.size() > 0) ? mk_frame(q.pop_front()) : 11'h7FF;
            m_pos   = 0;
        end else begin
            m_pos++;
        end
        if (acc) begin
            q.push_back(d);
            exp_bytes.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, a);
    endtask

    task automatic wait_pos(input int p);
        bit a;
        for (int i = 0; i < 12 && m_pos != p; i++) tick(1'b0, 8'h00, a);
        chk("wait_pos", m_pos, p);
    endtask

    // Asynchronous reset asserted mid-cycle; entered and left at a negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_frames_sent", frames_sent, 6'd0);
        tx_valid = 1'b0;
        m_pos    = 0;
        m_frame  = 11'h7FF;
        m_total  = 0;
        q.delete();
        exp_bytes.delete();
        rx_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          acc;
        int          idx;
        int          pushed;
        int          prev;
        logic [10:0] f;
        logic [7:0]  d;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        m_pos    = 0;
        m_frame  = 11'h7FF;
        m_total  = 0;
        rx_shift = '0;

        // Reset release, then idle line for 33 cycles.
        @(negedge clk);
        do_reset();
        idle(33);
        chk("idle_frames_sent", frames_sent, 6'd0);

        // Single byte 0xA5 pushed at bit_idx 3.
        wait_pos(3);
        tick(1'b1, 8'hA5, acc);
        chk("a5_accept", acc, 1'b1);
        idle(20);
        idx = -1;
        foreach (rx_log[i]) if (rx_log[i][0] == 1'b0) idx = i;
        chk("a5_found", idx >= 0, 1'b1);
        if (idx >= 0) chk("a5_frame", rx_log[idx], 11'h54A);
        chk("a5_frames_sent", frames_sent, 6'd1);

        // Two bytes back-to-back must produce adjacent data frames.
        rx_log.delete();
        tick(1'b1, 8'h01, acc);
        tick(1'b1, 8'h80, acc);
        idle(40);
        idx = -1;
        foreach (rx_log[i]) if (idx < 0 && rx_log[i][0] == 1'b0) idx = i;
        chk("b2b_found", (idx >= 0) && (idx + 1 < rx_log.size()), 1'b1);
        if ((idx >= 0) && (idx + 1 < rx_log.size())) begin
            chk("b2b_first", rx_log[idx], 11'h602);
            chk("b2b_second", rx_log[idx + 1], 11'h700);
        end

        // Five bytes from bit_idx 0: fill, stall, accept after the boundary pop.
        wait_pos(0);
        rx_log.delete();
        pushed = 0;
        for (int i = 0; i < 30 && pushed < 5; i++) begin
            d = 8'h10 + 8'(pushed);
            tick(1'b1, d, acc);
            if (acc) begin
                pushed++;
                if (pushed == 4) begin
                    chk("full_count", fifo_count, 3'd4);
                    chk("full_ready", tx_ready, 1'b0);
                end
            end
        end
        chk("five_pushed", pushed, 5);
        idle(70);
        idx = 0;
        foreach (rx_log[i]) begin
            if (rx_log[i][0] == 1'b0) begin
                d = 8'h10 + 8'(idx);
                chk("five_order", rx_log[i], mk_frame(d));
                idx++;
            end
        end
        chk("five_count", idx, 5);

        // Reset at bit_idx 5 of a data frame with two bytes still buffered.
        wait_pos(7);
        tick(1'b1, 8'h00, acc);
        tick(1'b1, 8'h0F, acc);
        tick(1'b1, 8'h33, acc);
        wait_pos(5);
        chk("pre_rst_count", fifo_count, 3'd2);
        chk("pre_rst_tx", tx, 1'b0);
        do_reset();
        idle(44);
        idx = 0;
        foreach (rx_log[i]) if (rx_log[i][0] == 1'b0) idx++;
        chk("post_rst_data_frames", idx, 0);
        chk("post_rst_frames_sent", frames_sent, 6'd0);

        // 65 random data frames; check the counter around its wrap.
        pushed = 0;
        for (int i = 0; i < 3000 && (pushed < 65 || m_total < 65); i++) begin
            prev = m_total;
            tick((pushed < 65) && ($urandom_range(0, 3) != 0), 8'($urandom), acc);
            if (acc) pushed++;
            if (m_total != prev) begin
                if (m_total == 63) chk("wrap_63", frames_sent, 6'd63);
                if (m_total == 64) chk("wrap_64", frames_sent, 6'd0);
                if (m_total == 65) chk("wrap_65", frames_sent, 6'd1);
            end
        end
        chk("rand_pushed", pushed, 65);
        idle(12);
        chk("rand_final_sent", frames_sent, 6'd1);
        chk("rand_drained", exp_bytes.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
